mic_level_meter: RTL and testbench

Consumer for the microphone side of the audio controller. It drains stereo samples using the `audio_in_available` / `read_audio_in` handshake and folds each stereo pair into a mono magnitude. It tracks the peak over a fixed window of samples and publishes a 7-bit level with a clip flag. The level feeds the visualiser, for example as a circle radius next to the note-driven radii, and other audio-reactive logic.

---
 rtl/audio_pkg.sv | 40 ++++
 rtl/mic_level_meter_if.sv | 38 +++
 rtl/stereo_magnitude.sv | 33 +++
 rtl/mic_level_meter.sv | 146 ++++++++++++++
 tb/tb_mic_level_meter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : audio_pkg
//  Description : Shared audio types and helpers: sample width, full-scale
//                constants, level-meter FSM state encoding, saturating abs.
//  Revision    : 1.0  initial release
// ============================================================================
package audio_pkg;

  // Audio controller sample width (signed two's complement).
  localparam int SAMPLE_W = 32;

  // Full-scale codes; either one in a sample counts as a clip event.
  localparam logic [SAMPLE_W-1:0] c_full_scale_pos = 32'h7FFF_FFFF;
  localparam logic [SAMPLE_W-1:0] c_full_scale_neg = 32'h8000_0000;

  // Level-meter FSM state encoding.
  localparam int c_state_w = 3;
  typedef enum logic [c_state_w-1:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_READ    = 3'd2,
    ST_ACC     = 3'd3,
    ST_PUBLISH = 3'd4
  } state_t;

  // Absolute value that never overflows: the most negative code folds onto
  // the most positive one instead of wrapping back to itself.
  function automatic logic [SAMPLE_W-1:0] sat_abs(input logic [SAMPLE_W-1:0] x);
    if (x == c_full_scale_neg) begin
      return c_full_scale_pos;
    end else if (x[SAMPLE_W-1]) begin
      return -x;
    end else begin
      return x;
    end
  endfunction

endpackage : audio_pkg
`default_nettype wire

// File: rtl/mic_level_meter_if.sv
`default_nettype none
// ============================================================================
//  Interface   : mic_level_meter_if
//  Description : Microphone-side handshake between the audio controller
//                (master) and a sample consumer such as the level meter
//                (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface mic_level_meter_if #(
  parameter int SAMPLE_W = 32
);

  logic                audio_in_available;
  logic [SAMPLE_W-1:0] left_channel_audio_in;
  logic [SAMPLE_W-1:0] right_channel_audio_in;
  logic                read_audio_in;
  logic                clear_audio_in_memory;

  // Controller side: offers sample pairs, receives pop and flush requests.
  modport master (
    output audio_in_available,
    output left_channel_audio_in,
    output right_channel_audio_in,
    input  read_audio_in,
    input  clear_audio_in_memory
  );

  // Consumer side: sees sample pairs, issues pop and flush requests.
  modport slave (
    input  audio_in_available,
    input  left_channel_audio_in,
    input  right_channel_audio_in,
    output read_audio_in,
    output clear_audio_in_memory
  );

endinterface : mic_level_meter_if
`default_nettype wire

// File: rtl/stereo_magnitude.sv
`default_nettype none
// ============================================================================
//  Module      : stereo_magnitude
//  Description : Folds a stereo sample pair into a mono magnitude
//                (|L| + |R|) / 2 and flags a full-scale sample on either
//                channel. Purely combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module stereo_magnitude
  import audio_pkg::*;
(
  input  wire logic [SAMPLE_W-1:0] i_left,
  input  wire logic [SAMPLE_W-1:0] i_right,
  output logic      [SAMPLE_W-1:0] o_mono,
  output logic                     o_clip_hit
);

  logic [SAMPLE_W-1:0] w_abs_left;
  logic [SAMPLE_W-1:0] w_abs_right;
  logic [SAMPLE_W:0]   w_sum;

  assign w_abs_left  = sat_abs(i_left);
  assign w_abs_right = sat_abs(i_right);

  // One extra bit keeps the sum exact; after halving the top bit is always 0.
  assign w_sum  = {1'b0, w_abs_left} + {1'b0, w_abs_right};
  assign o_mono = SAMPLE_W'(w_sum >> 1);

  assign o_clip_hit = (i_left  == c_full_scale_pos) || (i_left  == c_full_scale_neg) ||
                      (i_right == c_full_scale_pos) || (i_right == c_full_scale_neg);

endmodule : stereo_magnitude
`default_nettype wire

// File: rtl/mic_level_meter.sv
`default_nettype none
// ============================================================================
//  Module      : mic_level_meter
//  Description : Drains stereo microphone samples from the audio controller,
//                tracks the peak mono magnitude over a 2^WINDOW_LOG2-sample
//                window and publishes a LEVEL_W-bit level plus clip flag.
//  Revision    : 1.0  initial release
// ============================================================================
module mic_level_meter #(
  parameter int SAMPLE_W    = 32,
  parameter int WINDOW_LOG2 = 10,
  parameter int LEVEL_W     = 7
) (
  input  wire logic          clock,
  input  wire logic          resetn,
  input  wire logic          enable,
  mic_level_meter_if.slave   audio,
  output logic [LEVEL_W-1:0] level,
  output logic               level_valid,
  output logic               clipped
);

  import audio_pkg::*;

  state_t r_state;
  state_t w_next_state;

  logic [SAMPLE_W-1:0]    r_left;
  logic [SAMPLE_W-1:0]    r_right;
  logic [WINDOW_LOG2-1:0] r_count;
  logic [SAMPLE_W-1:0]    r_peak;
  logic                   r_clip_acc;
  logic [LEVEL_W-1:0]     r_level;
  logic                   r_clipped;

  logic [SAMPLE_W-1:0]    w_mono;
  logic                   w_clip_hit;
  logic [SAMPLE_W-1:0]    w_new_peak;
  logic                   w_clip_next;
  logic                   w_last;
  logic                   w_read;
  logic                   w_clear;
  logic                   w_valid;

  stereo_magnitude u_magnitude (
    .i_left     (r_left),
    .i_right    (r_right),
    .o_mono     (w_mono),
    .o_clip_hit (w_clip_hit)
  );

  assign w_new_peak  = (w_mono > r_peak) ? w_mono : r_peak;
  assign w_clip_next = r_clip_acc | w_clip_hit;
  assign w_last      = &r_count;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; READ always finishes its pop and runs ACC before
  // honouring a dropped enable.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (enable) w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (!enable)                       w_next_state = ST_IDLE;
        else if (audio.audio_in_available) w_next_state = ST_READ;
      end
      ST_READ:    w_next_state = ST_ACC;
      ST_ACC: begin
        if (!enable)     w_next_state = ST_IDLE;
        else if (w_last) w_next_state = ST_PUBLISH;
        else             w_next_state = ST_WAIT;
      end
      ST_PUBLISH: w_next_state = enable ? ST_WAIT : ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Moore output decode straight from the state register.
  always_comb begin
    w_read  = 1'b0;
    w_clear = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      ST_IDLE:    w_clear = 1'b1;
      ST_READ:    w_read  = 1'b1;
      ST_PUBLISH: w_valid = 1'b1;
      default:    ;
    endcase
  end

  assign audio.read_audio_in         = w_read;
  assign audio.clear_audio_in_memory = w_clear;
  assign level_valid                 = w_valid;
  assign level                       = r_level;
  assign clipped                     = r_clipped;

  // Sample capture, window accumulation and publish registers. The
  // published level/clip only change on the final sample of a window, so
  // they survive aborts and IDLE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_left     <= '0;
      r_right    <= '0;
      r_count    <= '0;
      r_peak     <= '0;
      r_clip_acc <= 1'b0;
      r_level    <= '0;
      r_clipped  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_count    <= '0;
          r_peak     <= '0;
          r_clip_acc <= 1'b0;
        end
        ST_READ: begin
          r_left  <= audio.left_channel_audio_in;
          r_right <= audio.right_channel_audio_in;
        end
        ST_ACC: begin
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_level    <= w_new_peak[SAMPLE_W-2 -: LEVEL_W];
            r_clipped  <= w_clip_next;
            r_peak     <= '0;
            r_clip_acc <= 1'b0;
          end else begin
            r_peak     <= w_new_peak;
            r_clip_acc <= w_clip_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : mic_level_meter
`default_nettype wire

// File: tb/tb_mic_level_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mic_level_meter
//  Description : Directed self-checking bench for mic_level_meter with a
//                4-sample window and a simple audio-controller model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mic_level_meter;

  localparam int SAMPLE_W    = 32;
  localparam int WINDOW_LOG2 = 2;
  localparam int LEVEL_W     = 7;

  logic               clock  = 1'b0;
  logic               resetn = 1'b0;
  logic               enable = 1'b0;
  logic [LEVEL_W-1:0] level;
  logic               level_valid;
  logic               clipped;

  mic_level_meter_if #(.SAMPLE_W(SAMPLE_W)) aif ();

  mic_level_meter #(
    .SAMPLE_W    (SAMPLE_W),
    .WINDOW_LOG2 (WINDOW_LOG2),
    .LEVEL_W     (LEVEL_W)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .enable      (enable),
    .audio       (aif),
    .level       (level),
    .level_valid (level_valid),
    .clipped     (clipped)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  int          cyc = 0;
  int          n_rd = 0;
  int          n_pub = 0;
  int          rd_cyc  [64];
  int          pub_cyc [16];
  logic [6:0]  pub_level [16];
  logic        pub_clip  [16];

  logic [31:0] q_l [64];
  logic [31:0] q_r [64];
  int          n_pairs = 0;
  int          idx = 0;
  bit          ctrl_busy = 1'b0;

  // Cycle counter.
  always @(posedge clock) cyc <= cyc + 1;

  // Record every pop and every publish as seen mid-cycle.
  always @(negedge clock) begin
    if (aif.read_audio_in) begin
      if (n_rd < 64) rd_cyc[n_rd] = cyc;
      n_rd = n_rd + 1;
    end
    if (level_valid) begin
      if (n_pub < 16) begin
        pub_cyc[n_pub]   = cyc;
        pub_level[n_pub] = level;
        pub_clip[n_pub]  = clipped;
      end
      n_pub = n_pub + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic present(input int i);
    aif.left_channel_audio_in  = q_l[i];
    aif.right_channel_audio_in = q_r[i];
    aif.audio_in_available     = 1'b1;
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] r);
    q_l[n_pairs] = l;
    q_r[n_pairs] = r;
    n_pairs++;
    if (!ctrl_busy && !aif.audio_in_available && idx < n_pairs) present(idx);
  endtask

  task automatic wait_pub(input string tag, input int target, input int budget);
    int k = 0;
    while (n_pub < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    check(tag, n_pub, target);
  endtask

  task automatic wait_rd(input string tag, input int target, input int budget);
    int k = 0;
    while (n_rd < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    check(tag, n_rd, target);
  endtask

  // Controller model: pops on the edge after a read strobe, drops available
  // for one cycle, then offers the next queued pair.
  initial begin
    aif.audio_in_available     = 1'b0;
    aif.left_channel_audio_in  = '0;
    aif.right_channel_audio_in = '0;
    forever begin
      @(negedge clock);
      if (resetn && aif.read_audio_in) begin
        ctrl_busy = 1'b1;
        @(posedge clock);
        #1;
        aif.audio_in_available = 1'b0;
        idx++;
        @(posedge clock);
        #1;
        if (idx < n_pairs) present(idx);
        ctrl_busy = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rel;
    int base_rd;
    int base_pub;
    int k;
    logic [6:0] exp_level [4];
    logic       exp_clip  [4];

    exp_level[0] = 7'h01; exp_clip[0] = 1'b0;
    exp_level[1] = 7'h3F; exp_clip[1] = 1'b1;
    exp_level[2] = 7'h00; exp_clip[2] = 1'b0;
    exp_level[3] = 7'h40; exp_clip[3] = 1'b0;

    #1;
    // Window 1: small equal pairs -> level 1.
    for (int i = 0; i < 4; i++) push(32'h0100_0000, 32'h0100_0000);
    // Window 2: negative full scale on pair 2 -> level 0x3F, clipped.
    push(32'h0, 32'h0);
    push(32'h8000_0000, 32'h0);
    push(32'h0, 32'h0);
    push(32'h0, 32'h0);
    // Window 3: silence.
    for (int i = 0; i < 4; i++) push(32'h0, 32'h0);
    // Window 4: mixed sign peak, then smaller samples.
    push(32'hC000_0000, 32'h4000_0000);
    for (int i = 0; i < 3; i++) push(32'h0010_0000, 32'h0010_0000);

    // Reset with enable and available held high.
    enable = 1'b1;
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_read",  aif.read_audio_in, 0);
    check("reset_level", level, 0);
    check("reset_valid", level_valid, 0);
    check("reset_clip",  clipped, 0);
    check("reset_clear", aif.clear_audio_in_memory, 1);

    rel = cyc;
    resetn = 1'b1;
    @(negedge clock);
    check("clear_drop", aif.clear_audio_in_memory, 0);
    check("no_early_read", aif.read_audio_in, 0);

    wait_pub("four_windows", 4, 200);
    check("first_read_cycle", rd_cyc[0], rel + 2);
    for (int i = 0; i < 15; i++)
      check($sformatf("read_spacing_%0d", i), rd_cyc[i+1] - rd_cyc[i], (i % 4 == 3) ? 4 : 3);
    for (int w = 0; w < 4; w++) begin
      check($sformatf("win%0d_level", w), pub_level[w], exp_level[w]);
      check($sformatf("win%0d_clip", w),  pub_clip[w],  exp_clip[w]);
      check($sformatf("win%0d_latency", w), pub_cyc[w], rd_cyc[4*w+3] + 2);
    end
    repeat (6) @(negedge clock);
    check("one_valid_per_window", n_pub, 4);

    // Abort after two pops: nothing published, level kept.
    base_rd  = n_rd;
    base_pub = n_pub;
    push(32'h2000_0000, 32'h2000_0000);
    push(32'h2000_0000, 32'h2000_0000);
    wait_rd("abort_two_reads", base_rd + 2, 50);
    repeat (3) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("abort_idle_clear", aif.clear_audio_in_memory, 1);
    repeat (3) @(negedge clock);
    check("abort_no_valid", n_pub, base_pub);
    check("abort_level_kept", level, 7'h40);

    // Re-enable with silence: no stale peak from the aborted window.
    for (int i = 0; i < 4; i++) push(32'h0, 32'h0);
    enable = 1'b1;
    wait_pub("reenable_publish", base_pub + 1, 100);
    check("reenable_level", pub_level[base_pub], 0);
    check("reenable_clip",  pub_clip[base_pub], 0);
    check("reenable_reads", n_rd, base_rd + 6);

    // Enable dropped during READ: pop completes, one ACC, then IDLE.
    base_rd  = n_rd;
    base_pub = n_pub;
    push(32'h3000_0000, 32'h3000_0000);
    push(32'h3000_0000, 32'h3000_0000);
    k = 0;
    while (!aif.read_audio_in && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("drop_read_seen", aif.read_audio_in, 1);
    enable = 1'b0;
    @(negedge clock);
    check("drop_acc_read", aif.read_audio_in, 0);
    check("drop_acc_clear", aif.clear_audio_in_memory, 0);
    @(negedge clock);
    check("drop_idle_clear", aif.clear_audio_in_memory, 1);
    repeat (10) @(negedge clock);
    check("drop_single_read", n_rd, base_rd + 1);
    check("drop_no_valid", n_pub, base_pub);

    // Pending 0x30000000 pair plus positive full scale -> level 0x3F, clipped.
    base_pub = n_pub;
    for (int i = 0; i < 3; i++) push(32'h7FFF_FFFF, 32'h0);
    enable = 1'b1;
    wait_pub("pos_fs_publish", base_pub + 1, 100);
    check("pos_fs_level", pub_level[base_pub], 7'h3F);
    check("pos_fs_clip",  pub_clip[base_pub], 1);

    // Asynchronous reset mid-window.
    base_rd  = n_rd;
    base_pub = n_pub;
    push(32'h1000_0000, 32'h1000_0000);
    push(32'h1000_0000, 32'h1000_0000);
    wait_rd("areset_two_reads", base_rd + 2, 50);
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    check("areset_level", level, 0);
    check("areset_clip",  clipped, 0);
    check("areset_read",  aif.read_audio_in, 0);
    check("areset_clear", aif.clear_audio_in_memory, 1);
    repeat (5) @(negedge clock);
    check("areset_no_valid", n_pub, base_pub);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mic_level_meter
`default_nettype wire
